// File: rtl/coin_collector.sv
// coin_collector: coin slot front-end for the vending controller.
// Accumulates saturating per-denomination counts and issues one purchase request.
module coin_collector #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coinValid,
    input  logic [1:0] coinType,
    input  logic       itemValid,
    input  logic [1:0] itemSel,
    input  logic       cancel,
    input  logic [1:0] serviceTypeIn,
    output logic [1:0] coinInNTD_50,
    output logic [1:0] coinInNTD_10,
    output logic [1:0] coinInNTD_5,
    output logic [1:0] coinInNTD_1,
    output logic [1:0] itemTypeIn,
    output logic       coinReject,
    output logic       refundValid,
    output logic [1:0] refundNTD_50,
    output logic [1:0] refundNTD_10,
    output logic [1:0] refundNTD_5,
    output logic [1:0] refundNTD_1,
    output logic [7:0] totalValue,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        ARMED   = 3'd2,
        ISSUE   = 3'd3,
        WAIT    = 3'd4
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0][1:0] cnt_q, cnt_d;
    logic [1:0]      item_q, item_d;
    logic [15:0]     tmo_q, tmo_d;
    logic            rej_q, rej_d;
    logic            rfv_q, rfv_d;
    logic [3:0][1:0] rf_q, rf_d;
    logic [3:0][1:0] req_q, req_d;
    logic [1:0]      reqitem_q, reqitem_d;
    logic [7:0]      total_q, total_d;
    logic            busy_q, busy_d;

    logic evt, expire, refund;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        item_d  = item_q;
        rej_d   = 1'b0;
        rfv_d   = 1'b0;
        rf_d    = '0;
        refund  = 1'b0;
        evt     = coinValid | itemValid;
        // an idle cycle that would reach the limit behaves as cancel
        expire  = !evt && (tmo_q == TMO_LAST);

        unique case (state_q)
            IDLE: begin
                if (coinValid) begin
                    cnt_d           = '0;
                    cnt_d[coinType] = 2'd1;
                    state_d         = COLLECT;
                end
            end
            COLLECT: begin
                if (coinValid) begin
                    if (cnt_q[coinType] == 2'd3) rej_d = 1'b1;
                    else cnt_d[coinType] = cnt_q[coinType] + 2'd1;
                end
                if (cancel || expire) begin
                    refund = 1'b1;
                end else if (itemValid && itemSel != 2'b00) begin
                    item_d  = itemSel;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                rej_d = coinValid;
                if (cancel || expire) refund = 1'b1;
                else if (serviceTypeIn == 2'b01) state_d = ISSUE;
            end
            ISSUE: begin
                rej_d   = coinValid;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                rej_d = coinValid;
                if (serviceTypeIn == 2'b00) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                item_d  = 2'd0;
                state_d = IDLE;
            end
        endcase

        if (refund) begin
            rfv_d   = 1'b1;
            rf_d    = cnt_d;
            cnt_d   = '0;
            item_d  = 2'd0;
            state_d = IDLE;
        end

        if (state_d != state_q || evt) tmo_d = '0;
        else if (state_q == COLLECT || state_q == ARMED) tmo_d = tmo_q + 16'd1;
        else tmo_d = '0;

        req_d     = (state_d == ISSUE) ? cnt_d : '0;
        reqitem_d = (state_d == ISSUE) ? item_d : 2'd0;
        busy_d    = (state_d == ARMED) || (state_d == ISSUE) || (state_d == WAIT);
        total_d   = 8'd50 * {6'd0, cnt_d[0]} + 8'd10 * {6'd0, cnt_d[1]}
                  + 8'd5 * {6'd0, cnt_d[2]} + {6'd0, cnt_d[3]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            item_q    <= 2'd0;
            tmo_q     <= '0;
            rej_q     <= 1'b0;
            rfv_q     <= 1'b0;
            rf_q      <= '0;
            req_q     <= '0;
            reqitem_q <= 2'd0;
            total_q   <= 8'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            item_q    <= item_d;
            tmo_q     <= tmo_d;
            rej_q     <= rej_d;
            rfv_q     <= rfv_d;
            rf_q      <= rf_d;
            req_q     <= req_d;
            reqitem_q <= reqitem_d;
            total_q   <= total_d;
            busy_q    <= busy_d;
        end
    end

    assign coinInNTD_50 = req_q[0];
    assign coinInNTD_10 = req_q[1];
    assign coinInNTD_5  = req_q[2];
    assign coinInNTD_1  = req_q[3];
    assign itemTypeIn   = reqitem_q;
    assign coinReject   = rej_q;
    assign refundValid  = rfv_q;
    assign refundNTD_50 = rf_q[0];
    assign refundNTD_10 = rf_q[1];
    assign refundNTD_5  = rf_q[2];
    assign refundNTD_1  = rf_q[3];
    assign totalValue   = total_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_coin_collector.sv
// tb_coin_collector: directed plan scenarios plus random traffic,
// compared cycle by cycle with a behavioural purchase model.
module tb_coin_collector;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       reset, coinValid, itemValid, cancel;
    logic [1:0] coinType, itemSel, serviceTypeIn;
    logic [1:0] coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn;
    logic       coinReject, refundValid, busy;
    logic [1:0] refundNTD_50, refundNTD_10, refundNTD_5, refundNTD_1;
    logic [7:0] totalValue;

    coin_collector #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .coinValid(coinValid), .coinType(coinType),
        .itemValid(itemValid), .itemSel(itemSel),
        .cancel(cancel), .serviceTypeIn(serviceTypeIn),
        .coinInNTD_50(coinInNTD_50), .coinInNTD_10(coinInNTD_10),
        .coinInNTD_5(coinInNTD_5), .coinInNTD_1(coinInNTD_1),
        .itemTypeIn(itemTypeIn), .coinReject(coinReject),
        .refundValid(refundValid),
        .refundNTD_50(refundNTD_50), .refundNTD_10(refundNTD_10),
        .refundNTD_5(refundNTD_5), .refundNTD_1(refundNTD_1),
        .totalValue(totalValue), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // purchase model: phases of a customer session, values from denomination table
    localparam int P_IDLE = 0, P_COLLECT = 1, P_ARMED = 2, P_ISSUE = 3, P_WAIT = 4;
    int m_ph = P_IDLE;
    int m_cnt[4] = '{default: 0};
    int m_item = 0;
    int m_idle = 0;
    int val[4] = '{50, 10, 5, 1};

    logic [9:0] e_req;
    logic [8:0] e_rf;
    logic       e_rej, e_busy;
    int         e_tot;

    task automatic model(input logic rst, input logic cv, input logic [1:0] ct,
                         input logic iv, input logic [1:0] is, input logic cc,
                         input logic [1:0] st);
        int  old;
        bit  evt, tout, rf;
        e_rej = 1'b0;
        e_rf  = '0;
        if (rst) begin
            m_ph = P_IDLE; m_cnt = '{default: 0}; m_item = 0; m_idle = 0;
        end else begin
            old  = m_ph;
            evt  = cv || iv;
            tout = !evt && (m_idle + 1 >= TMO);
            rf   = 0;
            case (m_ph)
                P_IDLE: if (cv) begin
                    m_cnt = '{default: 0}; m_cnt[ct] = 1; m_ph = P_COLLECT;
                end
                P_COLLECT: begin
                    if (cv) begin
                        if (m_cnt[ct] < 3) m_cnt[ct]++;
                        else e_rej = 1'b1;
                    end
                    if (cc || tout) rf = 1;
                    else if (iv && is != 2'b00) begin
                        m_item = int'(is); m_ph = P_ARMED;
                    end
                end
                P_ARMED: begin
                    e_rej = cv;
                    if (cc || tout) rf = 1;
                    else if (st == 2'b01) m_ph = P_ISSUE;
                end
                P_ISSUE: begin
                    e_rej = cv; m_cnt = '{default: 0}; m_ph = P_WAIT;
                end
                default: begin
                    e_rej = cv;
                    if (st == 2'b00) m_ph = P_IDLE;
                end
            endcase
            if (rf) begin
                e_rf = {1'b1, 2'(m_cnt[0]), 2'(m_cnt[1]), 2'(m_cnt[2]), 2'(m_cnt[3])};
                m_cnt = '{default: 0}; m_item = 0; m_ph = P_IDLE;
            end
            if (m_ph != old || evt) m_idle = 0;
            else if (m_ph == P_COLLECT || m_ph == P_ARMED) m_idle++;
        end
        e_req = '0;
        if (m_ph == P_ISSUE)
            e_req = {2'(m_cnt[0]), 2'(m_cnt[1]), 2'(m_cnt[2]), 2'(m_cnt[3]), 2'(m_item)};
        e_busy = (m_ph == P_ARMED) || (m_ph == P_ISSUE) || (m_ph == P_WAIT);
        e_tot = 0;
        for (int k = 0; k < 4; k++) e_tot += val[k] * m_cnt[k];
    endtask

    task automatic tick(input logic rst, input logic cv, input logic [1:0] ct,
                        input logic iv, input logic [1:0] is, input logic cc,
                        input logic [1:0] st);
        reset = rst; coinValid = cv; coinType = ct;
        itemValid = iv; itemSel = is; cancel = cc; serviceTypeIn = st;
        model(rst, cv, ct, iv, is, cc, st);
        @(posedge clk);
        #1;
        check("req", {coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn}, e_req);
        check("refund", {refundValid, refundNTD_50, refundNTD_10, refundNTD_5, refundNTD_1}, e_rf);
        check("reject", coinReject, e_rej);
        check("total", totalValue, e_tot);
        check("busy", busy, e_busy);
    endtask

    task automatic coin(input logic [1:0] ct, input logic [1:0] st);
        tick(1'b0, 1'b1, ct, 1'b0, 2'b00, 1'b0, st);
    endtask

    task automatic idle(input logic [1:0] st);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, st);
    endtask

    initial begin
        reset = 1'b1; coinValid = 1'b0; coinType = 2'b00;
        itemValid = 1'b0; itemSel = 2'b00; cancel = 1'b0; serviceTypeIn = 2'b00;

        tick(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);
        tick(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00);
        check("rst_total", totalValue, 0);
        check("rst_busy", busy, 0);

        // purchase of B with 10+5+1
        coin(2'b01, 2'b01);
        coin(2'b10, 2'b01);
        coin(2'b11, 2'b01);
        tick(1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 2'b01);
        check("t1_armed", busy, 1);
        idle(2'b01);
        check("t1_issue", {coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1, itemTypeIn},
              {2'd0, 2'd1, 2'd1, 2'd1, 2'b10});
        check("t1_total", totalValue, 16);
        idle(2'b01);
        check("t1_wait_req", itemTypeIn, 0);
        idle(2'b10);
        check("t1_wait_busy", busy, 1);
        idle(2'b00);
        check("t1_idle", busy, 0);

        // saturation of NTD1
        for (int i = 0; i < 4; i++) coin(2'b11, 2'b00);
        check("t2_reject", coinReject, 1);
        check("t2_total", totalValue, 3);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00);

        // cancel refund of two NTD50
        coin(2'b00, 2'b00);
        coin(2'b00, 2'b00);
        tick(1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00);
        check("t3_refund", {refundValid, refundNTD_50}, {1'b1, 2'd2});
        check("t3_total", totalValue, 0);

        // inactivity timeout
        coin(2'b10, 2'b00);
        for (int i = 0; i < 3; i++) idle(2'b00);
        check("t4_early", refundValid, 0);
        idle(2'b00);
        check("t4_refund", {refundValid, refundNTD_5}, {1'b1, 2'd1});

        // held in ARMED while controller busy
        coin(2'b00, 2'b10);
        tick(1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b0, 2'b10);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'(i % 2), 2'b11, 1'(1 - i % 2), 2'b00, 1'b0, 2'b10);
            check("t5_hold", {busy, coinInNTD_50, itemTypeIn}, {1'b1, 4'd0});
        end
        idle(2'b01);
        check("t5_issue", {coinInNTD_50, itemTypeIn}, {2'd1, 2'b01});
        idle(2'b01);
        check("t5_after", {coinInNTD_50, itemTypeIn}, 0);

        // reset in WAIT, then in COLLECT with coins held
        tick(1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01);
        check("t6_wait_rst", {busy, refundValid, totalValue}, 0);
        coin(2'b00, 2'b00);
        coin(2'b01, 2'b00);
        tick(1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00);
        check("t6_coll_rst", {busy, refundValid, totalValue}, 0);

        // random traffic, alternating busy and quiet stretches
        for (int i = 0; i < 3000; i++) begin
            bit quiet;
            logic rst, cv, iv, cc;
            logic [1:0] st;
            quiet = ((i / 25) % 3) == 2;
            rst = ($urandom_range(0, 199) == 0);
            if (quiet) begin
                cv = ($urandom_range(0, 15) == 0);
                iv = ($urandom_range(0, 31) == 0);
                cc = 1'b0;
                st = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'(2 * $urandom_range(0, 1));
            end else begin
                cv = ($urandom_range(0, 1) == 0);
                iv = ($urandom_range(0, 5) == 0);
                cc = ($urandom_range(0, 19) == 0);
                st = 2'($urandom_range(0, 2));
            end
            tick(rst, cv, 2'($urandom_range(0, 3)), iv, 2'($urandom_range(0, 3)), cc, st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
